memory_access: RTL and testbench
================================

// Module: memory_access
// PURPOSE
//  Memory stage of the in-order RV64 pipeline: consumes ex_mem, performs loads/stores over
//  the data bus (dreq/dresp), and registers the mem_wb bundle that writeback consumes.
//  Stalls upstream while a bus transaction is outstanding; non-memory ops pass in 1 cycle.
//  Detects misaligned accesses and raises a trap in mem_wb.trap instead of touching the bus.
// PARAMETERS
//  XLEN        64            data/address width
//  MMIO_LIMIT  64'h8000_0000 addresses below this are MMIO (used only with DIFFTEST_MMIO_SKIP_EN)
// PORTS
//  clk             in   1      clock, rising edge
//  rst_n           in   1      asynchronous, active-low reset
//  ex_mem_state    in   struct ex_mem bundle (valid, op, inst, inst_pc, value=addr, store data, csr, jump, trap, inst_counter)
//  flush           in   1      kill in-flight op (trap/jump redirect from writeback)
//  mem_stall       out  1      1 = hold ex_mem_state; upstream must not advance
//  mem_wb_state    out  struct registered mem_wb bundle to writeback
//  dreq_valid      out  1      data-bus request valid
//  dreq_addr       out  64     8-byte-aligned address
//  dreq_size       out  3      log2 bytes (0..3)
//  dreq_strobe     out  8      byte write enables; 0 = read
//  dreq_data       out  64     store data, shifted to lane
//  dresp_ok        in   1      1-cycle pulse: transaction done
//  dresp_data      in   64     read data (full aligned doubleword)
//  forward         out  reg_writer  bypass of result currently in mem_wb_state to decode
// BEHAVIOUR
//  Reset (rst_n=0, async): state=IDLE; mem_wb_state.valid=0, all mem_wb fields 0;
//   dreq_valid=0, dreq_strobe=0, mem_stall=0, forward.reg_write_enable=0.
//  FSM IDLE -> REQ -> IDLE:
//   IDLE: ex_mem valid & load/store & aligned & !flush -> latch op, enter REQ, mem_stall=1.
//         valid non-memory op -> copy to mem_wb_state next edge, mem_stall=0 (latency 1).
//         invalid input -> mem_wb_state.valid=0 next edge (bubble).
//   REQ:  dreq_valid=1, dreq_* held stable until dresp_ok. On dresp_ok: write mem_wb_state
//         (valid=1 unless killed), return IDLE, mem_stall drops same cycle as dresp_ok.
//         While in REQ, mem_wb_state.valid=0 each cycle.
//  Alignment: half needs addr[0]=0, word addr[1:0]=0, dword addr[2:0]=0. Misaligned:
//   no bus request; mem_wb_state.trap.trap_valid=1, trap_code=4 (load) / 6 (store),
//   latency 1, same path as non-memory op.
//  Store lane: dreq_data = rs2 << (8*addr[2:0]); strobe = ((1<<bytes)-1) << addr[2:0].
//  Load extract: raw = dresp_data >> (8*addr[2:0]); LB/LH/LW sign-extend from bit 7/15/31;
//   LBU/LHU/LWU zero-extend; LD = raw. Result into mem_wb_state.value.
//  flush: in IDLE, op is dropped (bubble). In REQ, request is NOT withdrawn (bus
//   protocol forbids); kill flag set, result discarded (valid=0) on dresp_ok.
//   flush and dresp_ok in same cycle -> result discarded.
//  dresp_ok while IDLE: ignored. Reset mid-REQ: FSM to IDLE, dreq_valid=0 immediately.
//  forward mirrors mem_wb_state writer fields; reg_write_enable=0 when valid=0.
// CONFIGURATION
//  DIFFTEST_MMIO_SKIP_EN defined: load/store with addr < MMIO_LIMIT sets
//   mem_wb_state.difftest_skip=1; otherwise difftest_skip passes from ex_mem_state.
//  Undefined: difftest_skip always copied from ex_mem_state; MMIO_LIMIT unused.
// TESTING
//  ADD through stage, no bus -> mem_wb_state.valid=1 next cycle, dreq_valid stays 0.
//  LB addr 0x8000_0003, dresp_data=0x0000_0000_8000_0000 after 3 cycles
//   -> mem_stall 1 for 3 cycles, value=0xFFFF_FFFF_FFFF_FF80.
//  SH rs2=0xBEEF addr 0x8000_0006 -> dreq_addr=0x8000_0000, strobe=0xC0, data=0xBEEF<<48.
//  LW addr 0x8000_0002 -> no dreq, trap_valid=1 code 4, valid=1 next cycle.
//  LD outstanding, flush asserted 1 cycle before dresp_ok -> dreq held until ok, result valid=0.
//  rst_n low while in REQ -> dreq_valid=0, mem_wb_state.valid=0 without waiting for clk.

Source files
------------

// File: rtl/memory_access.sv
// Memory stage of the in-order RV64 pipeline: data-bus loads/stores, misalignment traps, mem_wb register.
// Optional: define DIFFTEST_MMIO_SKIP_EN to mark loads/stores below MMIO_LIMIT with difftest_skip.
package memory_access_pkg;
  typedef enum logic [3:0] {
    OP_NOP, OP_ALU, OP_LB, OP_LH, OP_LW, OP_LD, OP_LBU, OP_LHU, OP_LWU,
    OP_SB, OP_SH, OP_SW, OP_SD
  } op_t;

  typedef struct packed {
    logic        csr_write;
    logic [11:0] csr_addr;
    logic [63:0] csr_value;
  } csr_t;

  typedef struct packed {
    logic        jump_valid;
    logic [63:0] jump_pc;
  } jump_t;

  typedef struct packed {
    logic       trap_valid;
    logic [3:0] trap_code;
  } trap_t;

  typedef struct packed {
    logic        valid;
    op_t         op;
    logic [31:0] inst;
    logic [63:0] inst_pc;
    logic [63:0] value;        // ALU result / effective address
    logic [63:0] store_data;   // rs2
    logic [4:0]  rd;
    logic        reg_write;
    csr_t        csr;
    jump_t       jump;
    trap_t       trap;
    logic [63:0] inst_counter;
    logic        difftest_skip;
  } ex_mem_t;

  typedef struct packed {
    logic        valid;
    op_t         op;
    logic [31:0] inst;
    logic [63:0] inst_pc;
    logic [63:0] value;
    logic [4:0]  rd;
    logic        reg_write;
    csr_t        csr;
    jump_t       jump;
    trap_t       trap;
    logic [63:0] inst_counter;
    logic        difftest_skip;
  } mem_wb_t;

  typedef struct packed {
    logic        reg_write_enable;
    logic [4:0]  rd;
    logic [63:0] value;
  } reg_writer_t;
endpackage

module memory_access
  import memory_access_pkg::*;
#(
  parameter int          XLEN       = 64,
  parameter logic [63:0] MMIO_LIMIT = 64'h8000_0000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  ex_mem_t          ex_mem_state,
  input  logic             flush,
  output logic             mem_stall,
  output mem_wb_t          mem_wb_state,
  output logic             dreq_valid,
  output logic [XLEN-1:0]  dreq_addr,
  output logic [2:0]       dreq_size,
  output logic [7:0]       dreq_strobe,
  output logic [XLEN-1:0]  dreq_data,
  input  logic             dresp_ok,
  input  logic [XLEN-1:0]  dresp_data,
  output reg_writer_t      forward
);

  typedef enum logic {IDLE, REQ} state_t;

  state_t    state, state_nx;
  ex_mem_t   req_q, req_nx;
  logic      kill_q, kill_nx;
  mem_wb_t   wb_nx;
  logic [XLEN-1:0] raw, load_val;
  logic [3:0]  bytes;
  logic [15:0] mask16, lane16;

  function automatic logic is_load(op_t op);
    return op inside {OP_LB, OP_LH, OP_LW, OP_LD, OP_LBU, OP_LHU, OP_LWU};
  endfunction

  function automatic logic is_store(op_t op);
    return op inside {OP_SB, OP_SH, OP_SW, OP_SD};
  endfunction

  function automatic logic [1:0] size_of(op_t op);
    case (op)
      OP_LH, OP_LHU, OP_SH: return 2'd1;
      OP_LW, OP_LWU, OP_SW: return 2'd2;
      OP_LD, OP_SD:         return 2'd3;
      default:              return 2'd0;
    endcase
  endfunction

  function automatic logic misaligned(op_t op, logic [2:0] a);
    case (size_of(op))
      2'd1:    return a[0];
      2'd2:    return a[1:0] != 2'b00;
      2'd3:    return a != 3'b000;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic skip_of(ex_mem_t e);
`ifdef DIFFTEST_MMIO_SKIP_EN
    return e.difftest_skip | ((is_load(e.op) | is_store(e.op)) & (e.value < MMIO_LIMIT));
`else
    return e.difftest_skip;
`endif
  endfunction

  function automatic mem_wb_t pass_wb(ex_mem_t e);
    mem_wb_t w;
    w.valid         = e.valid;
    w.op            = e.op;
    w.inst          = e.inst;
    w.inst_pc       = e.inst_pc;
    w.value         = e.value;
    w.rd            = e.rd;
    w.reg_write     = e.reg_write;
    w.csr           = e.csr;
    w.jump          = e.jump;
    w.trap          = e.trap;
    w.inst_counter  = e.inst_counter;
    w.difftest_skip = skip_of(e);
    return w;
  endfunction

  // Bus returns the whole aligned doubleword; shift the addressed byte to bit 0.
  assign raw = dresp_data >> {req_q.value[2:0], 3'b000};

  always_comb begin
    load_val = raw;
    case (req_q.op)
      OP_LB:   load_val = {{(XLEN-8){raw[7]}},   raw[7:0]};
      OP_LH:   load_val = {{(XLEN-16){raw[15]}}, raw[15:0]};
      OP_LW:   load_val = {{(XLEN-32){raw[31]}}, raw[31:0]};
      OP_LBU:  load_val = {{(XLEN-8){1'b0}},     raw[7:0]};
      OP_LHU:  load_val = {{(XLEN-16){1'b0}},    raw[15:0]};
      OP_LWU:  load_val = {{(XLEN-32){1'b0}},    raw[31:0]};
      default: load_val = raw;
    endcase
  end

  always_comb begin
    state_nx  = state;
    req_nx    = req_q;
    kill_nx   = kill_q;
    wb_nx     = '0;
    mem_stall = 1'b0;
    case (state)
      IDLE: begin
        if (ex_mem_state.valid && !flush) begin
          if ((is_load(ex_mem_state.op) || is_store(ex_mem_state.op)) &&
              !misaligned(ex_mem_state.op, ex_mem_state.value[2:0])) begin
            req_nx    = ex_mem_state;
            kill_nx   = 1'b0;
            state_nx  = REQ;
            mem_stall = 1'b1;
          end else begin
            wb_nx = pass_wb(ex_mem_state);
            // Misaligned access traps in place of the bus op and must not write rd.
            if (is_load(ex_mem_state.op) || is_store(ex_mem_state.op)) begin
              wb_nx.trap.trap_valid = 1'b1;
              wb_nx.trap.trap_code  = is_store(ex_mem_state.op) ? 4'd6 : 4'd4;
              wb_nx.reg_write       = 1'b0;
            end
          end
        end
      end
      REQ: begin
        kill_nx   = kill_q | flush;
        mem_stall = !dresp_ok;
        if (dresp_ok) begin
          wb_nx       = pass_wb(req_q);
          wb_nx.valid = !(kill_q || flush);
          if (is_load(req_q.op)) wb_nx.value = load_val;
          state_nx    = IDLE;
          kill_nx     = 1'b0;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      req_q        <= '0;
      kill_q       <= 1'b0;
      mem_wb_state <= '0;
    end else begin
      state        <= state_nx;
      req_q        <= req_nx;
      kill_q       <= kill_nx;
      mem_wb_state <= wb_nx;
    end
  end

  // Request fields come straight from the latched op, so they stay stable for the whole REQ.
  assign bytes  = 4'd1 << size_of(req_q.op);
  assign mask16 = (16'd1 << bytes) - 16'd1;
  assign lane16 = mask16 << req_q.value[2:0];

  assign dreq_valid  = (state == REQ);
  assign dreq_addr   = {req_q.value[XLEN-1:3], 3'b000};
  assign dreq_size   = {1'b0, size_of(req_q.op)};
  assign dreq_strobe = (dreq_valid && is_store(req_q.op)) ? lane16[7:0] : 8'h00;
  assign dreq_data   = req_q.store_data << {req_q.value[2:0], 3'b000};

  assign forward.reg_write_enable = mem_wb_state.valid & mem_wb_state.reg_write;
  assign forward.rd               = mem_wb_state.rd;
  assign forward.value            = mem_wb_state.value;

endmodule

// File: tb/tb_memory_access.sv
// Directed bench for memory_access: pass-through, loads, stores, misalignment, flush, reset.
module tb_memory_access;
  import memory_access_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  ex_mem_t     ex_mem_state;
  logic        flush = 1'b0;
  logic        mem_stall;
  mem_wb_t     mem_wb_state;
  logic        dreq_valid;
  logic [63:0] dreq_addr;
  logic [2:0]  dreq_size;
  logic [7:0]  dreq_strobe;
  logic [63:0] dreq_data;
  logic        dresp_ok = 1'b0;
  logic [63:0] dresp_data = '0;
  reg_writer_t forward;

  int total = 0;
  int bad   = 0;

  memory_access dut (
    .clk(clk), .rst_n(rst_n), .ex_mem_state(ex_mem_state), .flush(flush),
    .mem_stall(mem_stall), .mem_wb_state(mem_wb_state), .dreq_valid(dreq_valid),
    .dreq_addr(dreq_addr), .dreq_size(dreq_size), .dreq_strobe(dreq_strobe),
    .dreq_data(dreq_data), .dresp_ok(dresp_ok), .dresp_data(dresp_data),
    .forward(forward)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic ex_mem_t mk(op_t op, logic [63:0] addr, logic [63:0] rs2,
                                 logic [4:0] rd, logic rw);
    ex_mem_t e = '0;
    e.valid = 1'b1; e.op = op; e.value = addr; e.store_data = rs2;
    e.rd = rd; e.reg_write = rw; e.inst_pc = 64'h1000; e.inst = 32'h13;
    return e;
  endfunction

  task automatic test_reset();
    ex_mem_state = '0;
    rst_n = 1'b0;
    #12;
    total++; if (mem_wb_state !== '0) begin bad++; $display("FAIL reset_mem_wb got=%h exp=0", mem_wb_state); end
    total++; if (dreq_valid !== 1'b0 || dreq_strobe !== 8'h00) begin bad++; $display("FAIL reset_dreq got=%b/%h exp=0/00", dreq_valid, dreq_strobe); end
    total++; if (mem_stall !== 1'b0 || forward.reg_write_enable !== 1'b0) begin bad++; $display("FAIL reset_stall_fwd got=%b/%b exp=0/0", mem_stall, forward.reg_write_enable); end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_alu_pass();
    ex_mem_state = mk(OP_ALU, 64'h1234, 64'h0, 5'd5, 1'b1);
    ex_mem_state.difftest_skip = 1'b1;
    total++; if (mem_stall !== 1'b0 || dreq_valid !== 1'b0) begin bad++; $display("FAIL alu_no_stall got=%b/%b exp=0/0", mem_stall, dreq_valid); end
    tick();
    ex_mem_state = '0;
    total++; if (mem_wb_state.valid !== 1'b1 || mem_wb_state.value !== 64'h1234) begin bad++; $display("FAIL alu_wb got=%b/%h exp=1/1234", mem_wb_state.valid, mem_wb_state.value); end
    total++; if (forward.reg_write_enable !== 1'b1 || forward.rd !== 5'd5 || forward.value !== 64'h1234) begin bad++; $display("FAIL alu_fwd got=%b/%0d/%h exp=1/5/1234", forward.reg_write_enable, forward.rd, forward.value); end
    total++; if (mem_wb_state.difftest_skip !== 1'b1 || dreq_valid !== 1'b0) begin bad++; $display("FAIL alu_skip_nobus got=%b/%b exp=1/0", mem_wb_state.difftest_skip, dreq_valid); end
    tick();
    total++; if (mem_wb_state.valid !== 1'b0 || forward.reg_write_enable !== 1'b0) begin bad++; $display("FAIL bubble got=%b/%b exp=0/0", mem_wb_state.valid, forward.reg_write_enable); end
  endtask

  task automatic test_lb_wait();
    int stall_cycles = 0;
    ex_mem_state = mk(OP_LB, 64'h8000_0003, 64'h0, 5'd7, 1'b1);
    if (mem_stall) stall_cycles++;
    tick();
    total++; if (dreq_valid !== 1'b1 || dreq_addr !== 64'h8000_0000 || dreq_size !== 3'd0 || dreq_strobe !== 8'h00) begin bad++; $display("FAIL lb_req got=%b/%h/%0d/%h exp=1/80000000/0/00", dreq_valid, dreq_addr, dreq_size, dreq_strobe); end
    if (mem_stall) stall_cycles++;
    total++; if (mem_wb_state.valid !== 1'b0) begin bad++; $display("FAIL lb_wb_in_req got=%b exp=0", mem_wb_state.valid); end
    tick();
    if (mem_stall) stall_cycles++;
    tick();
    dresp_ok = 1'b1; dresp_data = 64'h0000_0000_8000_0000;
    if (mem_stall) stall_cycles++;
    total++; if (stall_cycles !== 3) begin bad++; $display("FAIL lb_stall_cycles got=%0d exp=3", stall_cycles); end
    total++; if (dreq_valid !== 1'b1 || dreq_addr !== 64'h8000_0000) begin bad++; $display("FAIL lb_req_held got=%b/%h exp=1/80000000", dreq_valid, dreq_addr); end
    tick();
    dresp_ok = 1'b0; ex_mem_state = '0;
    total++; if (mem_wb_state.valid !== 1'b1 || mem_wb_state.value !== 64'hFFFF_FFFF_FFFF_FF80) begin bad++; $display("FAIL lb_value got=%b/%h exp=1/ffffffffffffff80", mem_wb_state.valid, mem_wb_state.value); end
    total++; if (dreq_valid !== 1'b0 || forward.rd !== 5'd7) begin bad++; $display("FAIL lb_done got=%b/%0d exp=0/7", dreq_valid, forward.rd); end
    tick();
  endtask

  task automatic test_sh_store();
    ex_mem_state = mk(OP_SH, 64'h8000_0006, 64'hBEEF, 5'd0, 1'b0);
    tick();
    total++; if (dreq_addr !== 64'h8000_0000 || dreq_strobe !== 8'hC0 || dreq_size !== 3'd1) begin bad++; $display("FAIL sh_req got=%h/%h/%0d exp=80000000/c0/1", dreq_addr, dreq_strobe, dreq_size); end
    total++; if (dreq_data !== 64'hBEEF_0000_0000_0000) begin bad++; $display("FAIL sh_data got=%h exp=beef000000000000", dreq_data); end
    ex_mem_state = '0; dresp_ok = 1'b1;
    tick();
    dresp_ok = 1'b0;
    total++; if (mem_wb_state.valid !== 1'b1 || forward.reg_write_enable !== 1'b0 || mem_wb_state.trap.trap_valid !== 1'b0) begin bad++; $display("FAIL sh_wb got=%b/%b/%b exp=1/0/0", mem_wb_state.valid, forward.reg_write_enable, mem_wb_state.trap.trap_valid); end
    // Doubleword store: full strobe, no shift.
    ex_mem_state = mk(OP_SD, 64'h2000_0008, 64'h0123_4567_89AB_CDEF, 5'd0, 1'b0);
    tick();
    total++; if (dreq_strobe !== 8'hFF || dreq_data !== 64'h0123_4567_89AB_CDEF || dreq_size !== 3'd3) begin bad++; $display("FAIL sd_req got=%h/%h/%0d exp=ff/0123456789abcdef/3", dreq_strobe, dreq_data, dreq_size); end
    ex_mem_state = '0; dresp_ok = 1'b1;
    tick();
    dresp_ok = 1'b0;
    tick();
  endtask

  task automatic test_misaligned();
    ex_mem_state = mk(OP_LW, 64'h8000_0002, 64'h0, 5'd3, 1'b1);
    total++; if (mem_stall !== 1'b0) begin bad++; $display("FAIL mis_lw_stall got=%b exp=0", mem_stall); end
    tick();
    ex_mem_state = mk(OP_SD, 64'h8000_0004, 64'h55, 5'd0, 1'b0);
    total++; if (dreq_valid !== 1'b0) begin bad++; $display("FAIL mis_lw_nobus got=%b exp=0", dreq_valid); end
    total++; if (mem_wb_state.valid !== 1'b1 || mem_wb_state.trap.trap_valid !== 1'b1 || mem_wb_state.trap.trap_code !== 4'd4) begin bad++; $display("FAIL mis_lw_trap got=%b/%b/%0d exp=1/1/4", mem_wb_state.valid, mem_wb_state.trap.trap_valid, mem_wb_state.trap.trap_code); end
    tick();
    ex_mem_state = '0;
    total++; if (mem_wb_state.trap.trap_valid !== 1'b1 || mem_wb_state.trap.trap_code !== 4'd6 || dreq_valid !== 1'b0) begin bad++; $display("FAIL mis_sd_trap got=%b/%0d/%b exp=1/6/0", mem_wb_state.trap.trap_valid, mem_wb_state.trap.trap_code, dreq_valid); end
    tick();
  endtask

  task automatic test_loads();
    op_t         ops  [8] = '{OP_LBU, OP_LB, OP_LH, OP_LHU, OP_LW, OP_LWU, OP_LW, OP_LD};
    logic [63:0] addrs[8] = '{64'h10, 64'h10, 64'h12, 64'h12, 64'h10, 64'h14, 64'h14, 64'h10};
    logic [63:0] exps [8] = '{64'h88, 64'hFFFF_FFFF_FFFF_FF88, 64'hFFFF_FFFF_FFFF_8566,
                              64'h8566, 64'hFFFF_FFFF_8566_7788, 64'h1122_3344,
                              64'h1122_3344, 64'h1122_3344_8566_7788};
    for (int i = 0; i < 8; i++) begin
      ex_mem_state = mk(ops[i], addrs[i], 64'h0, 5'd9, 1'b1);
      tick();
      ex_mem_state = '0; dresp_ok = 1'b1; dresp_data = 64'h1122_3344_8566_7788;
      tick();
      dresp_ok = 1'b0;
      total++; if (mem_wb_state.valid !== 1'b1 || mem_wb_state.value !== exps[i]) begin bad++; $display("FAIL load_%0d got=%b/%h exp=1/%h", i, mem_wb_state.valid, mem_wb_state.value, exps[i]); end
    end
    tick();
  endtask

  task automatic test_flush_req();
    ex_mem_state = mk(OP_LD, 64'h8000_0010, 64'h0, 5'd4, 1'b1);
    tick();
    ex_mem_state = '0;
    tick();
    flush = 1'b1;
    total++; if (dreq_valid !== 1'b1 || mem_stall !== 1'b1) begin bad++; $display("FAIL flush_held got=%b/%b exp=1/1", dreq_valid, mem_stall); end
    tick();
    flush = 1'b0; dresp_ok = 1'b1; dresp_data = 64'hDEAD;
    total++; if (dreq_valid !== 1'b1 || dreq_addr !== 64'h8000_0010) begin bad++; $display("FAIL flush_not_withdrawn got=%b/%h exp=1/80000010", dreq_valid, dreq_addr); end
    tick();
    dresp_ok = 1'b0;
    total++; if (mem_wb_state.valid !== 1'b0 || forward.reg_write_enable !== 1'b0 || dreq_valid !== 1'b0) begin bad++; $display("FAIL flush_killed got=%b/%b/%b exp=0/0/0", mem_wb_state.valid, forward.reg_write_enable, dreq_valid); end
    // flush coincident with dresp_ok
    ex_mem_state = mk(OP_LW, 64'h40, 64'h0, 5'd4, 1'b1);
    tick();
    ex_mem_state = '0; flush = 1'b1; dresp_ok = 1'b1;
    tick();
    flush = 1'b0; dresp_ok = 1'b0;
    total++; if (mem_wb_state.valid !== 1'b0) begin bad++; $display("FAIL flush_same_cycle got=%b exp=0", mem_wb_state.valid); end
    // flush in IDLE drops the op
    ex_mem_state = mk(OP_ALU, 64'h77, 64'h0, 5'd2, 1'b1); flush = 1'b1;
    tick();
    ex_mem_state = '0; flush = 1'b0;
    total++; if (mem_wb_state.valid !== 1'b0) begin bad++; $display("FAIL flush_idle got=%b exp=0", mem_wb_state.valid); end
    tick();
  endtask

  task automatic test_dresp_idle();
    ex_mem_state = '0; dresp_ok = 1'b1;
    tick();
    dresp_ok = 1'b0;
    total++; if (mem_wb_state.valid !== 1'b0 || dreq_valid !== 1'b0) begin bad++; $display("FAIL dresp_idle got=%b/%b exp=0/0", mem_wb_state.valid, dreq_valid); end
    ex_mem_state = mk(OP_ALU, 64'h99, 64'h0, 5'd1, 1'b1);
    tick();
    ex_mem_state = '0;
    total++; if (mem_wb_state.valid !== 1'b1 || mem_wb_state.value !== 64'h99) begin bad++; $display("FAIL after_dresp_idle got=%b/%h exp=1/99", mem_wb_state.valid, mem_wb_state.value); end
    tick();
  endtask

  task automatic test_reset_mid_req();
    ex_mem_state = mk(OP_LD, 64'h8000_0020, 64'h0, 5'd6, 1'b1);
    tick();
    ex_mem_state = '0;
    total++; if (dreq_valid !== 1'b1) begin bad++; $display("FAIL rst_req_pre got=%b exp=1", dreq_valid); end
    #2 rst_n = 1'b0;
    #1;
    total++; if (dreq_valid !== 1'b0 || mem_wb_state.valid !== 1'b0 || mem_stall !== 1'b0) begin bad++; $display("FAIL rst_mid_req got=%b/%b/%b exp=0/0/0", dreq_valid, mem_wb_state.valid, mem_stall); end
    @(negedge clk);
    rst_n = 1'b1;
    dresp_ok = 1'b1;
    tick();
    dresp_ok = 1'b0;
    total++; if (mem_wb_state.valid !== 1'b0 || dreq_valid !== 1'b0) begin bad++; $display("FAIL rst_stale_resp got=%b/%b exp=0/0", mem_wb_state.valid, dreq_valid); end
  endtask

  initial begin
    ex_mem_state = '0;
    test_reset();
    test_alu_pass();
    test_lb_wait();
    test_sh_store();
    test_misaligned();
    test_loads();
    test_flush_req();
    test_dresp_idle();
    test_reset_mid_req();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
